// File: rtl/s2p_deframer.sv
// Serial-to-parallel deframer for the 1-Wire receive path: assembles run-time-length
// frames LSB- or MSB-first and presents each completed word on a valid/ready slot.
module s2p_deframer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b0,
  localparam int LEN_W    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_bit_valid,
  input  logic             i_bit_value,
  input  logic             i_sync_clr,
  input  logic [LEN_W-1:0] i_frame_len,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_data_valid,
  input  logic             i_data_ready,
  output logic             o_overrun,
  output logic             o_busy,
  output logic [LEN_W-1:0] o_bit_count
);

  typedef enum logic {S_IDLE, S_COLLECT} asm_state_t;
  typedef enum logic {S_EMPTY, S_FULL} slot_state_t;

  asm_state_t       r_asm, w_asm_nxt;
  slot_state_t      r_slot, w_slot_nxt;
  logic [LEN_W-1:0] r_bit_count, w_bit_count_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0] r_data_out, w_data_out_nxt;
  logic             r_overrun, w_overrun_nxt;

  logic [LEN_W-1:0] w_len_in;
  logic [LEN_W-1:0] w_len_eff;
  logic [31:0]      w_pos;
  logic [WIDTH-1:0] w_word;
  logic             w_accept;
  logic             w_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_asm       <= S_IDLE;
      r_slot      <= S_EMPTY;
      r_bit_count <= '0;
      r_len       <= LEN_W'(WIDTH);
      r_shift     <= '0;
      r_data_out  <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_asm       <= w_asm_nxt;
      r_slot      <= w_slot_nxt;
      r_bit_count <= w_bit_count_nxt;
      r_len       <= w_len_nxt;
      r_shift     <= w_shift_nxt;
      r_data_out  <= w_data_out_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_len_in = i_frame_len;
    if (i_frame_len == '0 || i_frame_len > LEN_W'(WIDTH))
      w_len_in = LEN_W'(WIDTH);

    // The first bit of a frame uses the live frame_len so L==1 completes at once.
    w_len_eff = (r_asm == S_IDLE) ? w_len_in : r_len;
    w_accept  = i_bit_valid && !i_sync_clr;
    w_done    = w_accept && (r_bit_count == w_len_eff - LEN_W'(1));

    if (MSB_FIRST)
      w_pos = 32'(w_len_eff) - 32'(r_bit_count) - 32'd1;
    else
      w_pos = 32'(r_bit_count);

    w_word = r_shift;
    for (int unsigned i = 0; i < WIDTH; i++)
      if (i == w_pos) w_word[i] = i_bit_value;

    w_asm_nxt       = r_asm;
    w_bit_count_nxt = r_bit_count;
    w_len_nxt       = r_len;
    w_shift_nxt     = r_shift;

    if (i_sync_clr) begin
      w_asm_nxt       = S_IDLE;
      w_bit_count_nxt = '0;
      w_shift_nxt     = '0;
    end else if (w_accept) begin
      if (r_asm == S_IDLE) w_len_nxt = w_len_in;
      if (w_done) begin
        w_asm_nxt       = S_IDLE;
        w_bit_count_nxt = '0;
        w_shift_nxt     = '0;
      end else begin
        w_asm_nxt       = S_COLLECT;
        w_bit_count_nxt = r_bit_count + LEN_W'(1);
        w_shift_nxt     = w_word;
      end
    end

    w_slot_nxt     = r_slot;
    w_data_out_nxt = r_data_out;
    w_overrun_nxt  = r_overrun;

    case (r_slot)
      S_EMPTY: begin
        if (w_done) begin
          w_data_out_nxt = w_word;
          w_slot_nxt     = S_FULL;
        end
      end
      S_FULL: begin
        if (w_done) begin
          if (i_data_ready) w_data_out_nxt = w_word;
          else              w_overrun_nxt  = 1'b1;
        end else if (i_data_ready) begin
          w_slot_nxt = S_EMPTY;
        end
      end
      default: w_slot_nxt = S_EMPTY;
    endcase

    if (i_sync_clr) w_overrun_nxt = 1'b0;
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = (r_slot == S_FULL);
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_bit_count != '0);
  assign o_bit_count  = r_bit_count;

endmodule

// File: tb/tb_s2p_deframer.sv
// Bench for s2p_deframer: LSB-first and MSB-first instances driven in parallel,
// compared every cycle against a queue-based frame model.
module tb_s2p_deframer;

  localparam int W  = 16;
  localparam int LW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          i_bit_valid, i_bit_value, i_sync_clr, i_data_ready;
  logic [LW-1:0] i_frame_len;

  logic [W-1:0]  dout0, dout1;
  logic          dval0, dval1, ovr0, ovr1, busy0, busy1;
  logic [LW-1:0] cnt0, cnt1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  s2p_deframer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .i_bit_valid(i_bit_valid), .i_bit_value(i_bit_value),
    .i_sync_clr(i_sync_clr), .i_frame_len(i_frame_len), .o_data_out(dout0),
    .o_data_valid(dval0), .i_data_ready(i_data_ready), .o_overrun(ovr0),
    .o_busy(busy0), .o_bit_count(cnt0)
  );

  s2p_deframer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .i_bit_valid(i_bit_valid), .i_bit_value(i_bit_value),
    .i_sync_clr(i_sync_clr), .i_frame_len(i_frame_len), .o_data_out(dout1),
    .o_data_valid(dval1), .i_data_ready(i_data_ready), .o_overrun(ovr1),
    .o_busy(busy1), .o_bit_count(cnt1)
  );

  // Reference model, index 0 = LSB-first, 1 = MSB-first
  bit           m_bits[2][$];
  int           m_len[2];
  logic [W-1:0] m_data[2];
  logic         m_valid[2];
  logic         m_ovr[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_bits[m].delete();
      m_len[m]   = W;
      m_data[m]  = '0;
      m_valid[m] = 1'b0;
      m_ovr[m]   = 1'b0;
    end
  endtask

  task automatic model_step(input logic bv, input logic bval, input logic clr,
                            input logic [LW-1:0] flen, input logic rdy);
    for (int m = 0; m < 2; m++) begin
      logic         done;
      logic [W-1:0] word;
      done = 1'b0;
      word = '0;
      if (clr) begin
        m_bits[m].delete();
      end else if (bv) begin
        if (m_bits[m].size() == 0)
          m_len[m] = (flen == 0 || int'(flen) > W) ? W : int'(flen);
        m_bits[m].push_back(bval);
        if (m_bits[m].size() == m_len[m]) begin
          for (int k = 0; k < m_len[m]; k++)
            word[(m == 1) ? (m_len[m] - 1 - k) : k] = m_bits[m][k];
          done = 1'b1;
          m_bits[m].delete();
        end
      end
      if (done) begin
        if (!m_valid[m] || rdy) begin
          m_data[m]  = word;
          m_valid[m] = 1'b1;
        end else begin
          m_ovr[m] = 1'b1;
        end
      end else if (m_valid[m] && rdy) begin
        m_valid[m] = 1'b0;
      end
      if (clr) m_ovr[m] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s.lsb.data", tag),  32'(dout0), 32'(m_data[0]));
    chk($sformatf("%s.lsb.valid", tag), 32'(dval0), 32'(m_valid[0]));
    chk($sformatf("%s.lsb.ovr", tag),   32'(ovr0),  32'(m_ovr[0]));
    chk($sformatf("%s.lsb.busy", tag),  32'(busy0), 32'(m_bits[0].size() != 0));
    chk($sformatf("%s.lsb.cnt", tag),   32'(cnt0),  32'(m_bits[0].size()));
    chk($sformatf("%s.msb.data", tag),  32'(dout1), 32'(m_data[1]));
    chk($sformatf("%s.msb.valid", tag), 32'(dval1), 32'(m_valid[1]));
    chk($sformatf("%s.msb.ovr", tag),   32'(ovr1),  32'(m_ovr[1]));
    chk($sformatf("%s.msb.busy", tag),  32'(busy1), 32'(m_bits[1].size() != 0));
    chk($sformatf("%s.msb.cnt", tag),   32'(cnt1),  32'(m_bits[1].size()));
  endtask

  task automatic cyc(input string tag, input logic bv, input logic bval, input logic clr,
                     input logic [LW-1:0] flen, input logic rdy);
    i_bit_valid  = bv;
    i_bit_value  = bval;
    i_sync_clr   = clr;
    i_frame_len  = flen;
    i_data_ready = rdy;
    @(posedge clk);
    model_step(bv, bval, clr, flen, rdy);
    #1;
    check_all(tag);
  endtask

  // bits[k] is the k-th serial bit; ready is rdy_rest except on the final bit
  task automatic send(input string tag, input logic [W-1:0] bits, input int n,
                      input logic [LW-1:0] flen, input logic rdy_last, input logic rdy_rest);
    for (int k = 0; k < n; k++)
      cyc(tag, 1'b1, bits[k], 1'b0, flen, (k == n - 1) ? rdy_last : rdy_rest);
  endtask

  initial begin
    rst          = 1'b1;
    i_bit_valid  = 1'b0;
    i_bit_value  = 1'b0;
    i_sync_clr   = 1'b0;
    i_frame_len  = '0;
    i_data_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // 8-bit frame 1,0,1,1,0,0,0,0 with the consumer stalled
    send("t1", 16'h000D, 8, LW'(8), 1'b0, 1'b0);
    chk("t1.lsb.word", 32'(dout0), 32'h000D);
    chk("t2.msb.word", 32'(dout1), 32'h00B0);
    chk("t1.valid", 32'(dval0), 32'd1);
    repeat (3) cyc("t2.hold", 1'b0, 1'b0, 1'b0, LW'(8), 1'b0);
    chk("t2.msb.stable", 32'(dout1), 32'h00B0);

    // Second word dropped while the slot is full
    send("t3a", 16'h00A5, 8, LW'(8), 1'b0, 1'b0);
    chk("t3.ovr", 32'(ovr0), 32'd1);
    chk("t3.kept", 32'(dout0), 32'h000D);
    cyc("t3.clr", 1'b0, 1'b0, 1'b1, LW'(8), 1'b0);
    chk("t3.ovr_clr", 32'(ovr0), 32'd0);
    send("t3b", 16'h003C, 8, LW'(8), 1'b1, 1'b0);
    chk("t3.load", 32'(dout0), 32'h003C);
    chk("t3.no_ovr", 32'(ovr0), 32'd0);
    cyc("t3.drain", 1'b0, 1'b0, 1'b0, LW'(8), 1'b1);

    // sync_clr aborts a partial frame and discards its own cycle's bit
    send("t4a", 16'h001F, 5, LW'(8), 1'b0, 1'b0);
    cyc("t4.clr", 1'b1, 1'b1, 1'b1, LW'(8), 1'b0);
    chk("t4.cnt", 32'(cnt0), 32'd0);
    chk("t4.busy", 32'(busy0), 32'd0);
    send("t4b", 16'h0081, 8, LW'(8), 1'b0, 1'b0);
    chk("t4.word", 32'(dout0), 32'h0081);
    cyc("t4.drain", 1'b0, 1'b0, 1'b0, LW'(8), 1'b1);

    // Out-of-range lengths map to full width; L=1 completes per bit
    send("t5.len0", 16'hBEEF, 16, LW'(0), 1'b1, 1'b1);
    chk("t5.len0.word", 32'(dout0), 32'hBEEF);
    send("t5.len20", 16'h1234, 16, LW'(20), 1'b1, 1'b1);
    chk("t5.len20.word", 32'(dout0), 32'h1234);
    cyc("t5.len1a", 1'b1, 1'b1, 1'b0, LW'(1), 1'b1);
    chk("t5.len1a.word", 32'(dout1), 32'h0001);
    cyc("t5.len1b", 1'b1, 1'b0, 1'b0, LW'(1), 1'b1);
    chk("t5.len1b.word", 32'(dout0), 32'h0000);
    chk("t5.len1b.cnt", 32'(cnt0), 32'd0);

    // Randomised traffic, including frame_len changes mid-frame
    for (int i = 0; i < 1500; i++)
      cyc("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 39) == 0), LW'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)));

    // Asynchronous reset with a pending word and a partial frame
    send("t6a", 16'h5A5A, 16, LW'(16), 1'b0, 1'b0);
    send("t6b", 16'h0007, 3, LW'(8), 1'b0, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all("t6.rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send("t6c", 16'h00C3, 8, LW'(8), 1'b0, 1'b0);
    chk("t6.recover", 32'(dout0), 32'h00C3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
